// File: rtl/dice_pkg.sv
// Shared types and defaults for the dice roll controller and its remainder unit.
// Pure declarations, so there is no latency and no flow control.
package dice_pkg;
    localparam int DEF_DICE_W  = 4;
    localparam int DEF_SIDES_W = 8;
    localparam int DEF_TOTAL_W = 12;
    localparam int DEF_TIMEOUT = 1024;
    localparam int DIV_CYCLES  = 32;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DIV,
        ACC,
        DONE
    } state_t;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/seq_mod32.sv
// Bit-serial 32-bit word mod divisor, MSB first: the remainder is valid with done_o, 32 cycles after start_i.
// There is no backpressure. A start_i while a division is running restarts the unit.
module seq_mod32
    import dice_pkg::*;
#(
    parameter int SIDES_W = DEF_SIDES_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic [31:0]        dividend_i,
    input  logic [SIDES_W-1:0] divisor_i,
    output logic               done_o,
    output logic [SIDES_W-1:0] rem_o
);
    localparam int CNT_W = $clog2(DIV_CYCLES);

    logic [31:0]        word_q, word_d;
    logic [SIDES_W:0]   rem_q, rem_d;
    logic [SIDES_W-1:0] div_q, div_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               run_q, run_d;
    logic               done_q, done_d;

    // rem_q holds the partial remainder with the next dividend bit already shifted in.
    // The conditional subtract is applied just before the next shift.
    function automatic logic [SIDES_W-1:0] reduce(input logic [SIDES_W:0]   x,
                                                  input logic [SIDES_W-1:0] d);
        if (x >= {1'b0, d}) begin
            return SIDES_W'(x - {1'b0, d});
        end
        return SIDES_W'(x);
    endfunction

    always_comb begin
        word_d = word_q;
        rem_d  = rem_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start_i) begin
            word_d = {dividend_i[30:0], 1'b0};
            rem_d  = {{SIDES_W{1'b0}}, dividend_i[31]};
            div_d  = divisor_i;
            cnt_d  = CNT_W'(1);
            run_d  = 1'b1;
        end else if (run_q) begin
            rem_d  = {reduce(rem_q, div_q), word_q[31]};
            word_d = {word_q[30:0], 1'b0};
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= '0;
            rem_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            word_q <= word_d;
            rem_q  <= rem_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done_o = done_q;
    assign rem_o  = reduce(rem_q, div_q);
endmodule

// File: rtl/dice_roll_ctrl.sv
// Rolls num_dice dice of `sides` faces through the RNG. Each die takes 1 + wait + 32 + 1 cycles, and each roll adds 1 more cycle.
// There is no backpressure. A roll request while busy is dropped, and rng_done outside WAIT is ignored.
module dice_roll_ctrl
    import dice_pkg::*;
#(
    parameter int DICE_W  = DEF_DICE_W,
    parameter int SIDES_W = DEF_SIDES_W,
    parameter int TOTAL_W = DEF_TOTAL_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               roll,
    input  logic [DICE_W-1:0]  num_dice,
    input  logic [SIDES_W-1:0] sides,
    output logic               rng_start,
    input  logic [31:0]        rng_result,
    input  logic               rng_done,
    output logic               busy,
    output logic [SIDES_W-1:0] last_face,
    output logic [TOTAL_W-1:0] total,
    output logic               total_valid,
    output logic               error
);
    localparam int WCNT_W = cnt_width(TIMEOUT);

    state_t             state_q, state_d;
    logic [DICE_W-1:0]  ndice_q, ndice_d;
    logic [DICE_W-1:0]  die_cnt_q, die_cnt_d;
    logic [SIDES_W-1:0] sides_q, sides_d;
    logic [SIDES_W-1:0] last_face_q, last_face_d;
    logic [TOTAL_W-1:0] total_q, total_d;
    logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               error_q, error_d;
    logic               mod_start, mod_done;
    logic [SIDES_W-1:0] mod_rem, face;

    seq_mod32 #(
        .SIDES_W (SIDES_W)
    ) u_mod (
        .clk        (clk),
        .reset      (reset),
        .start_i    (mod_start),
        .dividend_i (rng_result),
        .divisor_i  (sides_q),
        .done_o     (mod_done),
        .rem_o      (mod_rem)
    );

    assign face = mod_rem + SIDES_W'(1);

    always_comb begin
        state_d     = state_q;
        ndice_d     = ndice_q;
        die_cnt_d   = die_cnt_q;
        sides_d     = sides_q;
        last_face_d = last_face_q;
        total_d     = total_q;
        wait_cnt_d  = wait_cnt_q;
        error_d     = 1'b0;
        mod_start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (roll) begin
                    if (num_dice == '0 || sides == '0) begin
                        error_d = 1'b1;
                    end else begin
                        ndice_d   = num_dice;
                        sides_d   = sides;
                        total_d   = '0;
                        die_cnt_d = '0;
                        state_d   = REQ;
                    end
                end
            end
            REQ: begin
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (rng_done) begin
                    mod_start = 1'b1;
                    state_d   = DIV;
                end else if (wait_cnt_q == WCNT_W'(TIMEOUT - 1)) begin
                    // Give up on a stalled RNG and keep the partial sum for inspection.
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            DIV: begin
                if (mod_done) begin
                    state_d = ACC;
                end
            end
            ACC: begin
                total_d     = total_q + TOTAL_W'(face);
                last_face_d = face;
                die_cnt_d   = die_cnt_q + DICE_W'(1);
                state_d     = (die_cnt_d == ndice_q) ? DONE : REQ;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ndice_q     <= '0;
            die_cnt_q   <= '0;
            sides_q     <= '0;
            last_face_q <= '0;
            total_q     <= '0;
            wait_cnt_q  <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ndice_q     <= ndice_d;
            die_cnt_q   <= die_cnt_d;
            sides_q     <= sides_d;
            last_face_q <= last_face_d;
            total_q     <= total_d;
            wait_cnt_q  <= wait_cnt_d;
            error_q     <= error_d;
        end
    end

    assign rng_start   = (state_q == REQ);
    assign busy        = (state_q != IDLE);
    assign total_valid = (state_q == DONE);
    assign last_face   = last_face_q;
    assign total       = total_q;
    assign error       = error_q;
endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Directed and randomized rolls against an arithmetic model: face = word % sides + 1.
module tb_dice_roll_ctrl;
    localparam int TMO = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        roll;
    logic [3:0]  num_dice;
    logic [7:0]  sides;
    logic        rng_start;
    logic [31:0] rng_result = 32'h0;
    logic        rng_done = 1'b0;
    logic        busy;
    logic [7:0]  last_face;
    logic [11:0] total;
    logic        total_valid;
    logic        error;

    always #5 clk = ~clk;

    dice_roll_ctrl #(
        .DICE_W  (4),
        .SIDES_W (8),
        .TOTAL_W (12),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .roll        (roll),
        .num_dice    (num_dice),
        .sides       (sides),
        .rng_start   (rng_start),
        .rng_result  (rng_result),
        .rng_done    (rng_done),
        .busy        (busy),
        .last_face   (last_face),
        .total       (total),
        .total_valid (total_valid),
        .error       (error)
    );

    int chk_cnt = 0;
    int pass_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // RNG model: replies to each start with the next word after rsp_dly extra cycles.
    logic [31:0] words [16];
    int          n_words = 0;
    int          gen = 0;
    int          rsp_dly = 0;
    bit          stray_en = 1'b0;
    int          seen_gen = 0;
    int          idx = 0;
    bit          pending = 1'b0;
    int          dly_left = 0;
    int          stray_ctr = 0;

    always @(negedge clk) begin
        rng_done   = 1'b0;
        rng_result = $urandom;
        if (gen != seen_gen) begin
            seen_gen  = gen;
            idx       = 0;
            pending   = 1'b0;
            stray_ctr = 0;
        end
        if (stray_ctr != 0) begin
            stray_ctr--;
            if (stray_ctr == 0) rng_done = 1'b1;
        end
        if (pending) begin
            if (dly_left == 0) begin
                rng_done   = 1'b1;
                rng_result = words[idx];
                idx++;
                pending    = 1'b0;
                if (stray_en) stray_ctr = 10;
            end else begin
                dly_left--;
            end
        end
        if (rng_start && !reset && idx < n_words && !pending) begin
            pending  = 1'b1;
            dly_left = rsp_dly;
        end
    end

    int start_cnt = 0;
    int tv_cnt = 0;
    int err_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (rng_start)   start_cnt++;
        if (total_valid) tv_cnt++;
        if (error)       err_cnt++;
    end

    int unsigned last_total = 0;

    task automatic run_roll(input int nd, input int sd, input int dly, input bit noise, input string tag);
        int unsigned exp_total;
        int unsigned exp_last;
        int unsigned f;
        int          exp_lat;
        int          n_busy;
        int          n_tv;
        int          s0;
        int          t0;
        int          e0;
        logic [11:0] tot_seen;
        logic [7:0]  lf_seen;
        exp_total = 0;
        exp_last  = 0;
        for (int i = 0; i < nd; i++) begin
            f = (words[i] % sd) + 1;
            exp_total += f;
            exp_last = f;
        end
        exp_lat  = nd * (35 + dly) + 1;
        n_busy   = 0;
        n_tv     = 0;
        tot_seen = '0;
        lf_seen  = '0;
        rsp_dly  = dly;
        stray_en = noise;
        n_words  = nd;
        gen++;
        @(negedge clk);
        s0 = start_cnt;
        t0 = tv_cnt;
        e0 = err_cnt;
        roll     = 1'b1;
        num_dice = 4'(nd);
        sides    = 8'(sd);
        @(negedge clk);
        roll = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (!busy) break;
            n_busy++;
            if (total_valid) begin
                n_tv++;
                tot_seen = total;
                lf_seen  = last_face;
            end
            if (noise) begin
                roll     = 1'($urandom_range(0, 1));
                num_dice = 4'($urandom);
                sides    = 8'($urandom);
            end
            @(negedge clk);
        end
        roll     = 1'b0;
        num_dice = 4'(nd);
        sides    = 8'(sd);
        check({tag, ".idle_after"}, 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        check({tag, ".total"}, 32'(tot_seen), exp_total);
        check({tag, ".last_face"}, 32'(lf_seen), exp_last);
        check({tag, ".latency"}, n_busy, exp_lat);
        check({tag, ".tv_cycles"}, n_tv, 1);
        check({tag, ".tv_pulses"}, tv_cnt - t0, 1);
        check({tag, ".starts"}, start_cnt - s0, nd);
        check({tag, ".errors"}, err_cnt - e0, 0);
        check({tag, ".total_hold"}, 32'(total), exp_total);
        last_total = exp_total;
    endtask

    initial begin
        int s0;
        int t0;
        int e0;
        int n_busy;
        bit err_seen;
        reset    = 1'b1;
        roll     = 1'b0;
        num_dice = '0;
        sides    = '0;
        #1;
        check("rst.busy", 32'(busy), 0);
        check("rst.start", 32'(rng_start), 0);
        check("rst.total", 32'(total), 0);
        check("rst.last_face", 32'(last_face), 0);
        check("rst.tv", 32'(total_valid), 0);
        check("rst.error", 32'(error), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        words[0] = 32'h7;
        run_roll(1, 6, 2, 1'b0, "single");

        words[0] = 32'h5;
        words[1] = 32'hC;
        words[2] = 32'hFFFF_FFFF;
        run_roll(3, 6, 3, 1'b0, "three");

        // Invalid configurations: zero dice, then zero sides.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            s0 = start_cnt;
            e0 = err_cnt;
            roll     = 1'b1;
            num_dice = (k == 0) ? 4'd0 : 4'd2;
            sides    = (k == 0) ? 8'd6 : 8'd0;
            @(negedge clk);
            roll = 1'b0;
            check($sformatf("inval%0d.error", k), 32'(error), 1);
            check($sformatf("inval%0d.busy", k), 32'(busy), 0);
            @(negedge clk);
            check($sformatf("inval%0d.error_drop", k), 32'(error), 0);
            check($sformatf("inval%0d.busy2", k), 32'(busy), 0);
            check($sformatf("inval%0d.total", k), 32'(total), last_total);
            @(negedge clk);
            check($sformatf("inval%0d.starts", k), start_cnt - s0, 0);
            check($sformatf("inval%0d.err_pulses", k), err_cnt - e0, 1);
        end

        // RNG answers the first die only; the second die times out.
        words[0] = 32'h7;
        n_words  = 1;
        rsp_dly  = 0;
        stray_en = 1'b0;
        gen++;
        @(negedge clk);
        s0 = start_cnt;
        t0 = tv_cnt;
        e0 = err_cnt;
        roll     = 1'b1;
        num_dice = 4'd2;
        sides    = 8'd6;
        @(negedge clk);
        roll     = 1'b0;
        n_busy   = 0;
        err_seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!busy) begin
                err_seen = error;
                break;
            end
            n_busy++;
            @(negedge clk);
        end
        check("tmo.busy_cycles", n_busy, 35 + 1 + TMO);
        check("tmo.error_at_idle", 32'(err_seen), 1);
        repeat (2) @(negedge clk);
        check("tmo.partial_total", 32'(total), 2);
        check("tmo.last_face", 32'(last_face), 2);
        check("tmo.tv_pulses", tv_cnt - t0, 0);
        check("tmo.err_pulses", err_cnt - e0, 1);
        check("tmo.starts", start_cnt - s0, 2);

        // Busy filtering: roll/num_dice/sides noise and a stray rng_done in DIV.
        for (int i = 0; i < 4; i++) words[i] = $urandom;
        run_roll(4, 6, 1, 1'b1, "noise");

        for (int i = 0; i < 15; i++) words[i] = 32'hFFFF_FFFE;
        run_roll(15, 255, 0, 1'b1, "max");

        for (int i = 0; i < 3; i++) words[i] = $urandom;
        run_roll(3, 1, 0, 1'b0, "sides1");

        for (int r = 0; r < 6; r++) begin
            int nd;
            int sd;
            nd = $urandom_range(1, 4);
            sd = $urandom_range(1, 255);
            for (int i = 0; i < nd; i++) words[i] = $urandom;
            run_roll(nd, sd, $urandom_range(0, 6), 1'($urandom_range(0, 1)), $sformatf("rand%0d", r));
        end

        // Reset while the second die is in DIV.
        words[0] = 32'h3;
        words[1] = 32'h9;
        n_words  = 2;
        rsp_dly  = 0;
        stray_en = 1'b0;
        gen++;
        @(negedge clk);
        t0 = tv_cnt;
        e0 = err_cnt;
        s0 = start_cnt;
        roll     = 1'b1;
        num_dice = 4'd2;
        sides    = 8'd6;
        @(negedge clk);
        roll = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (start_cnt - s0 >= 2) break;
            @(negedge clk);
        end
        check("rstmid.second_start", start_cnt - s0, 2);
        repeat (6) @(negedge clk);
        check("rstmid.pre_total", 32'(total), 4);
        #2;
        reset = 1'b1;
        #1;
        check("rstmid.busy", 32'(busy), 0);
        check("rstmid.start", 32'(rng_start), 0);
        check("rstmid.total", 32'(total), 0);
        check("rstmid.last_face", 32'(last_face), 0);
        check("rstmid.tv", 32'(total_valid), 0);
        check("rstmid.error", 32'(error), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("rstmid.no_tv", tv_cnt - t0, 0);
        check("rstmid.no_err", err_cnt - e0, 0);
        check("rstmid.stays_idle", 32'(busy), 0);

        words[0] = 32'h7;
        run_roll(1, 6, 0, 1'b0, "after_rst");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/dice_roll_ctrl.md
Name: dice_roll_ctrl

Overview:
- Consumer stage directly downstream of the RNG block.
- On a roll request, issues one RNG start/done handshake per die.
- Reduces each 32-bit random word to a face value 1..sides with a sequential shift-subtract remainder.
- Accumulates the faces into a total and presents it with a one-cycle valid pulse to the display/UI logic.

Parameters:
- DICE_W, 4, width of num_dice; maximum dice per roll is 2^DICE_W-1.
- SIDES_W, 8, width of sides and face values.
- TOTAL_W, 12, width of total; must hold (2^DICE_W-1)*(2^SIDES_W-1) = 3825 at defaults.
- TIMEOUT, 1024, maximum cycles to wait for rng_done before aborting.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- roll  in  1  roll request; sampled only in IDLE.
- num_dice  in  DICE_W  dice count; latched when roll is accepted.
- sides  in  SIDES_W  faces per die; latched when roll is accepted.
- rng_start  out  1  one-cycle start pulse to RNG.
- rng_result  in  32  RNG output word; valid in the cycle rng_done=1.
- rng_done  in  1  RNG completion pulse.
- busy  out  1  high in every state except IDLE.
- last_face  out  SIDES_W  face of the most recently completed die.
- total  out  TOTAL_W  sum of faces for the current/last roll.
- total_valid  out  1  one-cycle pulse when total is final.
- error  out  1  one-cycle pulse on invalid config or RNG timeout.

Behaviour:
- Reset (async, immediate): state=IDLE; rng_start=0, busy=0, last_face=0, total=0, total_valid=0, error=0; all counters cleared.
- Reset asserted mid-roll aborts the roll; no total_valid or error pulse is emitted.
- IDLE:
  - roll=1 with num_dice=0 or sides=0: stay IDLE, pulse error next cycle, total unchanged.
  - roll=1 with valid config: latch num_dice and sides, clear total and the die counter, go to REQ.
- REQ: rng_start=1 for exactly one cycle; go to WAIT.
- WAIT:
  - Capture rng_result on the cycle rng_done=1; go to DIV.
  - The wait counter increments each cycle without rng_done. Reaching TIMEOUT goes to IDLE and pulses error; total keeps its partial sum and no total_valid is emitted.
  - rng_done in any state other than WAIT is ignored.
- DIV:
  - 32-cycle restoring remainder of the captured word mod latched sides, processing MSB first.
  - The remainder register is SIDES_W+1 bits; subtract when remainder >= sides.
  - After 32 cycles, face = remainder+1, truncated to SIDES_W. The range is 1..sides, so no overflow.
  - sides=1 always yields face 1.
- ACC:
  - total <= total + face; last_face <= face; die counter increments.
  - If counter == latched num_dice, go to DONE; else go to REQ.
- DONE: total_valid=1 for one cycle; go to IDLE.
- Latency per die: 1 (REQ) + W (wait cycles including the done cycle) + 32 (DIV) + 1 (ACC).
- Latency per roll: sum of the per-die latencies + 1 (DONE).
- roll while busy is ignored (not queued).
- Changing num_dice/sides during a roll has no effect.
- The next roll may be accepted in the cycle after DONE.
- Bias from the non-power-of-two modulus is accepted; there is no rejection sampling.

Decomposition:
- Shared package dice_pkg holds:
  - state enum (IDLE, REQ, WAIT, DIV, ACC, DONE);
  - default widths DICE_W/SIDES_W/TOTAL_W;
  - DIV_CYCLES=32;
  - TIMEOUT default.
- One natural sub-module: seq_mod32. It computes a 32-bit word mod a SIDES_W divisor via start/done, taking 32 cycles, and is reusable by other dice modes.

Test Plan:
- Reset during DIV of the second die: all outputs 0 immediately. A following roll (num_dice=1, sides=6, rng_result=7) gives total=2, total_valid pulses once.
- Single die: num_dice=1, sides=6, rng_result=0x00000007 -> rng_start pulses once, last_face=2, total=2, total_valid exactly 1 cycle.
- Three dice with sides=6:
  - rng_result sequence 0x5, 0xC, 0xFFFFFFFF -> faces 6, 1, 4 and total=11.
  - Exactly 3 rng_start pulses.
  - Latency = 3*(34+W)+1.
- Invalid config: roll with num_dice=0 (sides=6), then with sides=0 (num_dice=2) -> error pulse each, no rng_start, busy stays 0.
- Timeout: rng_done never asserted -> error pulses after TIMEOUT cycles in WAIT, state returns to IDLE, no total_valid.
- Busy filtering and extremes:
  - roll pulses during an active roll are ignored.
  - Stray rng_done in DIV is ignored.
  - num_dice=15, sides=255, every rng_result=0xFFFFFFFE (mod 255 = 254) -> total=3825 with no overflow.
